// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file and the address-width helper.
package regfile_sb_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_NWR   = 2;

  // Smallest AW with 2**AW >= n.
  function automatic int calc_aw(input int n);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) aw = i + 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, qualified write clears, set wins on a tie.
// Busy lookup is combinational and masked by a same-cycle write; never stalls anything itself.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter int NWR   = DEF_NWR,
  parameter int AW    = calc_aw(DEF_NREGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NWR-1:0]    wr_qual,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              issue_stall
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  always_ff @(posedge CLK) begin
    pending_q <= pending_d;
  end

  always_comb begin
    pending_d = pending_q;
    if (RESET) begin
      pending_d = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p]) pending_d[wr_addr[p*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a new producer stays outstanding.
      if (issue_en && (issue_addr != '0)) pending_d[issue_addr] = 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = pending_q[rd_addr[i*AW +: AW]] && (rd_addr[i*AW +: AW] != '0);
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) rd_busy[i] = 1'b0;
      end
    end
    issue_stall = issue_en && (|rd_busy);
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a pending-producer scoreboard.
// Reads are zero-latency, writes commit on the next edge; stall is advisory only.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  parameter int NWR   = DEF_NWR,
  localparam int AW   = calc_aw(NREGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NRD*AW-1:0]   RD_ADDR,
  output logic [NRD*XLEN-1:0] RD_DATA,
  output logic [NRD-1:0]      RD_BUSY,
  input  logic [NWR-1:0]      WR_EN,
  input  logic [NWR*AW-1:0]   WR_ADDR,
  input  logic [NWR*XLEN-1:0] WR_DATA,
  input  logic                INST_VALID,
  input  logic                ISSUE_EN,
  input  logic [AW-1:0]       ISSUE_ADDR,
  output logic                ISSUE_STALL
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NWR-1:0]  wr_qual;

  // A write is real only when globally valid, outside reset and not aimed at r0.
  always_comb begin
    wr_qual = '0;
    for (int p = 0; p < NWR; p++) begin
      wr_qual[p] = WR_EN[p] && INST_VALID && !RESET && (WR_ADDR[p*AW +: AW] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  always_comb begin
    regs_d = regs_q;
    if (RESET) begin
      for (int r = 0; r < NREGS; r++) regs_d[r] = '0;
    end else begin
      // Ascending port order: the highest-numbered port wins on an address clash.
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p]) regs_d[WR_ADDR[p*AW +: AW]] = WR_DATA[p*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  always_comb begin
    RD_DATA = '0;
    for (int i = 0; i < NRD; i++) begin
      RD_DATA[i*XLEN +: XLEN] = regs_q[RD_ADDR[i*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (wr_qual[p] && (WR_ADDR[p*AW +: AW] == RD_ADDR[i*AW +: AW])) begin
          RD_DATA[i*XLEN +: XLEN] = WR_DATA[p*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .CLK         (CLK),
    .RESET       (RESET),
    .wr_qual     (wr_qual),
    .wr_addr     (WR_ADDR),
    .issue_en    (ISSUE_EN),
    .issue_addr  (ISSUE_ADDR),
    .rd_addr     (RD_ADDR),
    .rd_busy     (RD_BUSY),
    .issue_stall (ISSUE_STALL)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, r0, scoreboard, qualifiers, reset mid-burst.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic              clk;
  logic              reset;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              inst_valid;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              issue_stall;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb dut (
    .CLK         (clk),
    .RESET       (reset),
    .RD_ADDR     (rd_addr),
    .RD_DATA     (rd_data),
    .RD_BUSY     (rd_busy),
    .WR_EN       (wr_en),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .INST_VALID  (inst_valid),
    .ISSUE_EN    (issue_en),
    .ISSUE_ADDR  (issue_addr),
    .ISSUE_STALL (issue_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    inst_valid = 1'b0; issue_en = 1'b0; issue_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
    inst_valid = 1'b1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; set_rd(5'd0, 5'd0);
    tick(); tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      set_rd(a[AW-1:0], 5'(31 - a));
      @(negedge clk);
      n_checks++;
      if (rd_data !== '0) begin
        n_fail++; $display("FAIL reset_rd_data addr=%0d got %h want 0", a, rd_data);
      end
      n_checks++;
      if (rd_busy !== 2'b00 || issue_stall !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy addr=%0d got busy=%b stall=%b want 00/0", a, rd_busy, issue_stall);
      end
    end
    tick();
  endtask

  task automatic test_multi_write();
    idle(); set_rd(5'd5, 5'd6);
    set_wr(0, 5'd5, 32'h0000_00AA);
    set_wr(1, 5'd5, 32'h0000_00BB);
    @(negedge clk);
    n_checks++;
    if (rd_data[31:0] !== 32'h0000_00BB) begin
      n_fail++; $display("FAIL multi_write_bypass got %h want 000000bb", rd_data[31:0]);
    end
    n_checks++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL multi_write_other got %h want 0", rd_data[63:32]);
    end
    tick(); idle(); set_rd(5'd6, 5'd5);
    @(negedge clk);
    n_checks++;
    if (rd_data[63:32] !== 32'h0000_00BB) begin
      n_fail++; $display("FAIL multi_write_stored got %h want 000000bb", rd_data[63:32]);
    end
    tick();
  endtask

  task automatic test_r0();
    idle(); set_rd(5'd0, 5'd0);
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    issue_en = 1'b1; issue_addr = 5'd0;
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL r0_same_cycle got data=%h busy=%b want 0/00", rd_data, rd_busy);
    end
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL r0_after got data=%h busy=%b want 0/00", rd_data, rd_busy);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle(); issue_en = 1'b1; issue_addr = 5'd7; set_rd(5'd7, 5'd8);
    @(negedge clk);
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL sb_before_edge got %b want 00", rd_busy);
    end
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (rd_busy !== 2'b01 || issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL sb_busy_noissue got busy=%b stall=%b want 01/0", rd_busy, issue_stall);
    end
    issue_en = 1'b1; issue_addr = 5'd0;
    #1;
    n_checks++;
    if (rd_busy !== 2'b01 || issue_stall !== 1'b1) begin
      n_fail++; $display("FAIL sb_stall got busy=%b stall=%b want 01/1", rd_busy, issue_stall);
    end
    tick(); idle(); set_wr(1, 5'd7, 32'h0000_1234);
    @(negedge clk);
    n_checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL sb_write_clear got busy=%b data=%h want 00/00001234", rd_busy, rd_data[31:0]);
    end
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL sb_after_clear got busy=%b data=%h want 00/00001234", rd_busy, rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_issue_write_same();
    idle(); set_rd(5'd9, 5'd9);
    issue_en = 1'b1; issue_addr = 5'd9;
    set_wr(0, 5'd9, 32'h0000_0055);
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (rd_data[31:0] !== 32'h0000_0055) begin
      n_fail++; $display("FAIL iw_data got %h want 00000055", rd_data[31:0]);
    end
    n_checks++;
    if (rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL iw_pending got %b want 11", rd_busy);
    end
    tick();
  endtask

  task automatic test_qualifiers();
    idle(); set_rd(5'd3, 5'd9);
    set_wr(0, 5'd3, 32'h0000_0077); inst_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL invalid_bypass got %h want 0", rd_data[31:0]);
    end
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL invalid_store got %h want 0", rd_data[31:0]);
    end
    set_wr(0, 5'd3, 32'h0000_0077); reset = 1'b1;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL reset_bypass got %h want 0", rd_data[31:0]);
    end
    tick(); idle();
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_write_drop got data=%h busy=%b want 0/00", rd_data, rd_busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(); set_wr(0, 5'd10, 32'h0000_0001); issue_en = 1'b1; issue_addr = 5'd12;
    tick(); idle(); set_wr(1, 5'd11, 32'h0000_0002);
    tick(); idle(); set_rd(5'd10, 5'd11);
    @(negedge clk);
    n_checks++;
    if (rd_data !== {32'h2, 32'h1}) begin
      n_fail++; $display("FAIL b2b_stored got %h want 0000000200000001", rd_data);
    end
    set_rd(5'd12, 5'd13);
    #1;
    n_checks++;
    if (rd_busy !== 2'b01) begin
      n_fail++; $display("FAIL b2b_pending got %b want 01", rd_busy);
    end
    reset = 1'b1; set_wr(0, 5'd13, 32'h0000_0003); issue_en = 1'b1; issue_addr = 5'd14;
    tick(); idle(); set_rd(5'd10, 5'd11);
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++; $display("FAIL b2b_reset_clear got %h want 0", rd_data);
    end
    set_rd(5'd12, 5'd13);
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL b2b_reset_drop got data=%h busy=%b want 0/00", rd_data, rd_busy);
    end
    set_rd(5'd14, 5'd14); issue_en = 1'b1;
    #1;
    n_checks++;
    if (rd_busy !== 2'b00 || issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL b2b_issue_drop got busy=%b stall=%b want 00/0", rd_busy, issue_stall);
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    rd_addr = '0;
    test_reset();
    test_multi_write();
    test_r0();
    test_scoreboard();
    test_issue_write_same();
    test_qualifiers();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
